// File: rtl/cla_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial word adder.
package cla_seq_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam int NIB_W       = 4;
  localparam int MAX_NIBBLES = 16;

  // Nibble index width; a single-nibble word still needs a 1-bit index.
  function automatic int idx_w(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/cla_word_sequencer_if.sv
// Request/result valid-ready bus of the nibble-serial adder.
// Carries out_ovf only when CLA_SEQ_OVF_EN is defined.
interface cla_word_sequencer_if
  import cla_seq_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIB_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

`ifdef CLA_SEQ_OVF_EN
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`endif

endinterface

// File: rtl/cla_seq_opreg.sv
// Operand and partial-sum storage with nibble select and nibble write-back.
// Provides the overflow flag when CLA_SEQ_OVF_EN is defined.
module cla_seq_opreg
  import cla_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_i,
  input  logic [NIB_W*NIBBLES-1:0]      a_i,
  input  logic [NIB_W*NIBBLES-1:0]      b_i,
  input  logic                          wr_en_i,
  input  logic [idx_w(NIBBLES)-1:0]     idx_i,
  input  logic [NIB_W-1:0]              wr_nib_i,
  output logic [NIB_W-1:0]              x_o,
  output logic [NIB_W-1:0]              y_o,
`ifdef CLA_SEQ_OVF_EN
  output logic                          ovf_o,
`endif
  output logic [NIB_W*NIBBLES-1:0]      sum_d_o
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = idx_w(NIBBLES);

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (load_i) begin
      a_q <= a_i;
      b_q <= b_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       sum_q <= '0;
    else if (load_i)  sum_q <= '0;
    else if (wr_en_i) sum_q <= sum_d_o;
  end

  // sum_d_o already carries the nibble being written this cycle.
  always_comb begin
    x_o     = '0;
    y_o     = '0;
    sum_d_o = sum_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_i == IDX_W'(i)) begin
        x_o = a_q[i*NIB_W +: NIB_W];
        y_o = b_q[i*NIB_W +: NIB_W];
        if (wr_en_i) sum_d_o[i*NIB_W +: NIB_W] = wr_nib_i;
      end
    end
  end

`ifdef CLA_SEQ_OVF_EN
  assign ovf_o = (a_q[W-1] == b_q[W-1]) && (sum_d_o[W-1] != a_q[W-1]);
`endif

endmodule

// File: rtl/cla_word_sequencer.sv
// Multi-nibble adder driving one external 4-bit CLA, LSB nibble first.
// Optional signed-overflow output enabled by CLA_SEQ_OVF_EN.
module cla_word_sequencer
  import cla_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  cla_word_sequencer_if.slave bus,
  output logic [NIB_W-1:0]   cla_x,
  output logic [NIB_W-1:0]   cla_y,
  output logic               cla_cin,
  input  logic [NIB_W-1:0]   cla_z,
  input  logic               cla_cout
);

  localparam int                 W        = NIB_W * NIBBLES;
  localparam int                 IDX_W    = idx_w(NIBBLES);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             cin_q;
  logic             out_valid_q;
  logic             out_cout_q;
  logic [W-1:0]     out_sum_q;
  logic [W-1:0]     sum_d;
  logic [NIB_W-1:0] x_nib;
  logic [NIB_W-1:0] y_nib;
  logic             busy;
  logic             last;
  logic             accept;
`ifdef CLA_SEQ_OVF_EN
  logic             ovf_d;
  logic             ovf_q;
  assign bus.out_ovf = ovf_q;
`endif

  assign busy         = (state_q == BUSY);
  assign last         = (idx_q == LAST_IDX);
  assign bus.in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign cla_x   = busy ? x_nib : '0;
  assign cla_y   = busy ? y_nib : '0;
  assign cla_cin = busy && ((idx_q == '0) ? cin_q : carry_q);

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;

  cla_seq_opreg #(.NIBBLES(NIBBLES)) u_opreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .a_i      (bus.in_a),
    .b_i      (bus.in_b),
    .wr_en_i  (busy),
    .idx_i    (idx_q),
    .wr_nib_i (cla_z),
    .x_o      (x_nib),
    .y_o      (y_nib),
`ifdef CLA_SEQ_OVF_EN
    .ovf_o    (ovf_d),
`endif
    .sum_d_o  (sum_d)
  );

  // The visible result is captured only on the final nibble, so it holds through BUSY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= BUSY;
            idx_q   <= '0;
            cin_q   <= bus.in_cin;
          end
        end
        BUSY: begin
          carry_q <= cla_cout;
          if (last) begin
            state_q     <= DONE;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_sum_q   <= sum_d;
            out_cout_q  <= cla_cout;
`ifdef CLA_SEQ_OVF_EN
            ovf_q       <= ovf_d;
`endif
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              state_q <= BUSY;
              idx_q   <= '0;
              cin_q   <= bus.in_cin;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Directed bench for cla_word_sequencer (NIBBLES=4) with a behavioural CLA.
// Adds overflow checks when CLA_SEQ_OVF_EN is defined.
module tb_cla_word_sequencer;
  import cla_seq_pkg::*;

  localparam int NIBBLES = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cla_x;
  logic [3:0] cla_y;
  logic [3:0] cla_z;
  logic       cla_cin;
  logic       cla_cout;
  int         vectors     = 0;
  int         miscompares = 0;
  logic [15:0] held;

  logic [15:0] t5_a    [3] = '{16'h0001, 16'h8000, 16'hABCD};
  logic [15:0] t5_b    [3] = '{16'h0002, 16'h8000, 16'h1111};
  logic [15:0] t5_sum  [3] = '{16'h0003, 16'h0000, 16'hBCDE};
  logic        t5_cout [3] = '{1'b0, 1'b1, 1'b0};
  logic        t5_ovf  [3] = '{1'b0, 1'b1, 1'b0};

  cla_word_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

  cla_word_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cla_x    (cla_x),
    .cla_y    (cla_y),
    .cla_cin  (cla_cin),
    .cla_z    (cla_z),
    .cla_cout (cla_cout)
  );

  assign {cla_cout, cla_z} = {1'b0, cla_x} + {1'b0, cla_y} + {4'b0000, cla_cin};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    #1;
    chk("accept_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_busy(input string tag, input logic [3:0] cin_mask,
                          input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_cla_cin"}, 32'(cla_cin), 32'(cin_mask[i]));
      chk({tag, "_sum_held"}, 32'(bus.out_sum), 32'(held));
      tick();
    end
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_out_sum"}, 32'(bus.out_sum), 32'(exp_sum));
    chk({tag, "_out_cout"}, 32'(bus.out_cout), 32'(exp_cout));
`ifdef CLA_SEQ_OVF_EN
    chk({tag, "_out_ovf"}, 32'(bus.out_ovf), 32'(exp_ovf));
`endif
    held = exp_sum;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    #1;
    chk("consume_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("consume_out_valid", 32'(bus.out_valid), 32'd0);
    chk("consume_idle_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    held          = '0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_out_cout", 32'(bus.out_cout), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_cla_x", 32'(cla_x), 32'd0);
    chk("rst_cla_cin", 32'(cla_cin), 32'd0);
`ifdef CLA_SEQ_OVF_EN
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
`endif

    // Plain add, no carries
    accept_op(16'h1234, 16'h4321, 1'b0);
    chk("t1_cla_x0", 32'(cla_x), 32'h4);
    chk("t1_cla_y0", 32'(cla_y), 32'h1);
    run_busy("t1", 4'b0000, 16'h5555, 1'b0, 1'b0);
    consume();

    // Carry ripples through every nibble
    accept_op(16'hFFFF, 16'h0001, 1'b0);
    run_busy("t2", 4'b1110, 16'h0000, 1'b1, 1'b0);
    consume();

    // Initial carry-in drives the whole chain
    accept_op(16'hFFFF, 16'h0000, 1'b1);
    run_busy("t3", 4'b1111, 16'h0000, 1'b1, 1'b0);
    consume();

    // Backpressure in DONE with a pending request
    accept_op(16'h1234, 16'h1111, 1'b0);
    run_busy("t4", 4'b0000, 16'h2345, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h0F0F;
    bus.in_b     = 16'h00F1;
    bus.in_cin   = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_sum", 32'(bus.out_sum), 32'h2345);
      chk("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t4_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    run_busy("t4b", 4'b1110, 16'h1000, 1'b0, 1'b0);
    consume();

    // Back-to-back: a new accept every 5 cycles
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = t5_a[k];
      bus.in_b     = t5_b[k];
      bus.in_cin   = 1'b0;
      #1;
      chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      run_busy("t5", 4'b0000, t5_sum[k], t5_cout[k], t5_ovf[k]);
    end
    bus.in_valid = 1'b0;
    #1;
    tick();
    chk("t5_drain_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_drain_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;

    // Reset in the middle of an add
    accept_op(16'h1234, 16'h4321, 1'b0);
    tick();
    tick();
    chk("t6_cla_x2", 32'(cla_x), 32'h2);
    chk("t6_cla_y2", 32'(cla_y), 32'h3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t6_out_sum", 32'(bus.out_sum), 32'd0);
    chk("t6_cla_x", 32'(cla_x), 32'd0);
    held = '0;
    repeat (6) tick();
    chk("t6_no_result", 32'(bus.out_valid), 32'd0);

    // Signed overflow boundary
    accept_op(16'h7FFF, 16'h0001, 1'b0);
    run_busy("t7a", 4'b1110, 16'h8000, 1'b0, 1'b1);
    consume();
    accept_op(16'h0001, 16'h0001, 1'b0);
    run_busy("t7b", 4'b0000, 16'h0002, 1'b0, 1'b0);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
